instr_aligner: RTL and testbench
================================

Name: instr_aligner

Overview:
- Fetch-side realignment buffer between the instruction fetch bus and the decode stage.
- Accepts 32-bit word-aligned fetch data and holds it as a halfword FIFO.
- Presents one complete instruction per handshake to decode: 16-bit RVC in the low half, or a 32-bit instruction that may span two fetched words.
- Tracks the PC of the presented instruction and propagates fetch bus errors.

Parameters:
- DEPTH, 4, buffer capacity in halfwords; even, >= 4.
- BOOT_ADDR, 32'h0000_0000, PC loaded at reset; bit 0 is 0.

Ports:
- s_clk_i  in  1  clock
- s_rst_i  in  1  asynchronous reset, active-high
- s_flush_i  in  1  discard buffer, restart at s_flush_addr_i
- s_flush_addr_i  in  32  new PC; bit 1 may be set, bit 0 ignored
- s_fvalid_i  in  1  fetch word valid
- s_fdata_i  in  32  fetched word; halfword 0 in [15:0]
- s_ferr_i  in  1  bus error on this fetch word
- s_fready_o  out  1  word accepted when s_fvalid_i & s_fready_o
- s_ivalid_o  out  1  instruction valid to decode
- s_iready_i  in  1  decode consumes when s_ivalid_o & s_iready_i
- s_instr_o  out  32  instruction; RVC form is {16'b0, hw}
- s_rvc_o  out  1  presented instruction is 16-bit
- s_pc_o  out  32  PC of the presented instruction
- s_ierr_o  out  1  fetch error on any halfword of the presented instruction

Behaviour:
- State: halfword array [DEPTH], per-entry error bits, read and write pointers that wrap modulo DEPTH, occupancy count 0..DEPTH, head PC register, skip_first flag.
- Reset (async): count=0, pointers=0, skip_first=0, head PC=BOOT_ADDR.
  - Outputs at reset: s_ivalid_o=0, s_fready_o=1, s_rvc_o=0, s_ierr_o=0, s_instr_o=0, s_pc_o=BOOT_ADDR.
- s_fready_o = (DEPTH - count) >= 2, computed from registered count. No same-cycle credit from consumption.
- Enqueue on a fetch handshake:
  - skip_first=0: write both halfwords in order, count+=2. The error bit of both entries = s_ferr_i.
  - skip_first=1: write only [31:16], count+=1, then clear skip_first.
- Head classification: hw0 = entry at read pointer, hw1 = next entry.
  - hw0[1:0]!=2'b11: RVC, length 1.
  - Otherwise: 32-bit, length 2.
- s_ivalid_o is combinational from registered state.
  - Asserted if count>=1 and (RVC or hw0 error bit set), or if count>=2.
  - Forced 0 in any cycle with s_flush_i=1.
- Errored head:
  - If hw0's error bit is set, present immediately with length 1 and s_ierr_o=1.
  - Do not wait for hw1, whose data may never arrive.
  - In this case s_rvc_o = (hw0[1:0]!=2'b11).
- For a 32-bit head with count>=2: s_instr_o={hw1,hw0}, s_ierr_o = err(hw0)|err(hw1).
- On a decode handshake: read pointer += length, count -= length, head PC += 2*length (mod 2^32).
- Simultaneous enqueue and consume in one cycle: count updates by +enqueued -consumed.
  - The array write and read never conflict, because the fready rule guarantees free slots.
- s_instr_o, s_rvc_o and s_pc_o are don't-care-stable when s_ivalid_o=0. They must still reflect the head entry so they do not X-propagate. Unused entries reset to 0.
- Flush, highest priority, effective at the clock edge:
  - count=0, pointers=0, head PC = {s_flush_addr_i[31:1],1'b0}, skip_first = s_flush_addr_i[1].
  - Any same-cycle fetch word or decode handshake is ignored. Fetch is responsible for re-requesting from the word-aligned flush address.
  - The first instruction after a flush is visible no earlier than 2 cycles after the flush cycle (fetch word in the next cycle, output the cycle after).
- Latency: a word accepted at edge N makes its instruction valid in the cycle after edge N.
- Reset mid-operation discards everything, identical to the reset state.
- A halfword with bits [1:0]=2'b11 at the last slot of a word waits in the buffer until the next word arrives; no stall beyond that.
- Illegal-instruction and prediction checks are done downstream; this block never inspects bits beyond [1:0].

Test Plan:
- Reset, then words 32'h4505_4501 and 32'h0000_8082 (RVC li a0,0; li a0,1; ret).
  - Required: three RVC outputs with PCs 0x0, 0x2, 0x4 and s_instr_o=32'h0000_4501, 32'h0000_4505, 32'h0000_8082.
  - After the third handshake the head is the low halfword 0x0000 of the second word; s_ivalid_o stays 1 and presents it as RVC at PC 0x6.
- Spanning 32-bit instruction: word0=32'h0093_4501, word1=32'h0000_0010.
  - Required: RVC 0x4501 at PC 0, then s_instr_o=32'h0010_0093 (addi x1,x0,1) at PC 2 with s_rvc_o=0.
  - s_ivalid_o stays 0 for the second instruction until word1 is enqueued.
- Flush to 0x0000_0102 with the same-cycle fetch word valid.
  - Required: that word is dropped and s_ivalid_o=0 in the flush cycle.
  - Next word 32'h4505_xxxx yields only RVC 0x4505 at PC 0x102; low halfword discarded.
- Backpressure, DEPTH=4, s_iready_i=0, four RVC words offered.
  - Required: s_fready_o=1 for the first two words, 0 after count=4.
  - Raising s_iready_i for one cycle drains one entry (count=3), so s_fready_o stays 0 until count<=2.
- Error word: s_ferr_i=1 with data 32'hFFFF_FFFF.
  - Required: output valid next cycle, s_ierr_o=1, s_rvc_o=0, length 1, PC advances by 2.
  - The next output is also s_ierr_o=1.
- Assert s_rst_i asynchronously mid-stream with count=3.
  - Required: s_ivalid_o=0, s_fready_o=1, s_pc_o=BOOT_ADDR immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/instr_aligner.sv
// Instruction realignment buffer. Fetch words are split into halfwords and
// kept in a small circular FIFO, and one complete instruction is presented to
// decode per handshake: a 16-bit RVC instruction, or a 32-bit instruction that
// may span two fetch words. Tracks the head PC and carries fetch bus errors.
module instr_aligner #(
  parameter int unsigned DEPTH     = 4,
  parameter logic [31:0] BOOT_ADDR = 32'h0000_0000
) (
  input  logic        s_clk_i,
  input  logic        s_rst_i,
  input  logic        s_flush_i,
  input  logic [31:0] s_flush_addr_i,
  input  logic        s_fvalid_i,
  input  logic [31:0] s_fdata_i,
  input  logic        s_ferr_i,
  output logic        s_fready_o,
  output logic        s_ivalid_o,
  input  logic        s_iready_i,
  output logic [31:0] s_instr_o,
  output logic        s_rvc_o,
  output logic [31:0] s_pc_o,
  output logic        s_ierr_o
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam logic [PW:0]   DEPTH_W = (PW + 1)'(DEPTH);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [15:0]       mem [DEPTH];
  logic [DEPTH-1:0]  err_q;
  logic [PW-1:0]     rd_ptr;
  logic [PW-1:0]     wr_ptr;
  logic [CW-1:0]     count;
  logic [31:0]       head_pc;
  logic              skip_first;

  logic [PW-1:0]     rd_nxt;
  logic [PW-1:0]     wr_nxt;
  logic [15:0]       hw0;
  logic [15:0]       hw1;
  logic              e0;
  logic              e1;
  logic              head_rvc;
  logic              len_one;
  logic              has1;
  logic              has2;
  logic              enq;
  logic              deq;
  logic [1:0]        enq_n;
  logic [1:0]        deq_n;
  logic [CW-1:0]     count_nxt;

  // Bit 0 of the flush address is ignored: instructions are halfword aligned.
  logic unused_flush_bit0;
  assign unused_flush_bit0 = s_flush_addr_i[0];

  // Pointer advance with wrap modulo DEPTH (DEPTH need not be a power of two).
  function automatic logic [PW-1:0] ptr_add(input logic [PW-1:0] p, input logic [1:0] n);
    logic [PW:0] s;
    s = {1'b0, p} + {{(PW - 1){1'b0}}, n};
    if (s >= DEPTH_W) s = s - DEPTH_W;
    return s[PW-1:0];
  endfunction

  // Head classification, decode-side outputs and handshake bookkeeping.
  always_comb begin
    rd_nxt     = ptr_add(rd_ptr, 2'd1);
    wr_nxt     = ptr_add(wr_ptr, 2'd1);
    hw0        = mem[rd_ptr];
    hw1        = mem[rd_nxt];
    e0         = err_q[rd_ptr];
    e1         = err_q[rd_nxt];
    head_rvc   = (hw0[1:0] != 2'b11);
    // An errored head is released alone so decode never waits on a halfword
    // that the faulting fetch may never deliver.
    len_one    = head_rvc | e0;
    has1       = (count != '0);
    has2       = (count >= CW'(2));
    s_fready_o = ((DEPTH_C - count) >= CW'(2));
    s_ivalid_o = !s_flush_i && ((has1 && len_one) || has2);
    s_instr_o  = len_one ? {16'h0000, hw0} : {hw1, hw0};
    s_rvc_o    = has1 && head_rvc;
    s_ierr_o   = len_one ? e0 : (e0 | e1);
    s_pc_o     = head_pc;
    enq        = s_fvalid_i && s_fready_o;
    deq        = s_ivalid_o && s_iready_i;
    enq_n      = enq ? (skip_first ? 2'd1 : 2'd2) : 2'd0;
    deq_n      = deq ? (len_one ? 2'd1 : 2'd2) : 2'd0;
    count_nxt  = count + CW'(enq_n) - CW'(deq_n);
  end

  // Buffer storage, pointers, occupancy, head PC and flush restart.
  always_ff @(posedge s_clk_i or posedge s_rst_i) begin
    if (s_rst_i) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
      err_q      <= '0;
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count      <= '0;
      head_pc    <= BOOT_ADDR;
      skip_first <= 1'b0;
    end else if (s_flush_i) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count      <= '0;
      head_pc    <= {s_flush_addr_i[31:1], 1'b0};
      skip_first <= s_flush_addr_i[1];
    end else begin
      if (enq) begin
        if (skip_first) begin
          mem[wr_ptr]   <= s_fdata_i[31:16];
          err_q[wr_ptr] <= s_ferr_i;
          wr_ptr        <= wr_nxt;
          skip_first    <= 1'b0;
        end else begin
          mem[wr_ptr]   <= s_fdata_i[15:0];
          mem[wr_nxt]   <= s_fdata_i[31:16];
          err_q[wr_ptr] <= s_ferr_i;
          err_q[wr_nxt] <= s_ferr_i;
          wr_ptr        <= ptr_add(wr_ptr, 2'd2);
        end
      end
      if (deq) begin
        rd_ptr  <= ptr_add(rd_ptr, deq_n);
        head_pc <= head_pc + (len_one ? 32'd2 : 32'd4);
      end
      count <= count_nxt;
    end
  end

endmodule

// File: tb/tb_instr_aligner.sv
// Scoreboard bench for instr_aligner: expected instructions are queued as
// stimulus is driven and compared whenever decode accepts an instruction.
module tb_instr_aligner;

  localparam logic [31:0] BOOT = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic [31:0] flush_addr;
  logic        fvalid;
  logic [31:0] fdata;
  logic        ferr;
  logic        fready;
  logic        ivalid;
  logic        iready;
  logic [31:0] instr;
  logic        rvc;
  logic [31:0] pc;
  logic        ierr;

  typedef struct packed {
    logic [31:0] instr;
    logic        rvc;
    logic [31:0] pc;
    logic        ierr;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  instr_aligner #(.DEPTH(4), .BOOT_ADDR(BOOT)) dut (
    .s_clk_i(clk), .s_rst_i(rst), .s_flush_i(flush), .s_flush_addr_i(flush_addr),
    .s_fvalid_i(fvalid), .s_fdata_i(fdata), .s_ferr_i(ferr), .s_fready_o(fready),
    .s_ivalid_o(ivalid), .s_iready_i(iready), .s_instr_o(instr), .s_rvc_o(rvc),
    .s_pc_o(pc), .s_ierr_o(ierr)
  );

  always #5 clk = ~clk;

  // Decode-side monitor: every accepted instruction is checked against the queue.
  always @(negedge clk) begin
    if (!rst && ivalid && iready) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_output: got instr=%h rvc=%b pc=%h ierr=%b, none expected",
                 instr, rvc, pc, ierr);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if ({instr, rvc, pc, ierr} !== e) begin
          errors++;
          $display("FAIL output: got instr=%h rvc=%b pc=%h ierr=%b, expected instr=%h rvc=%b pc=%h ierr=%b",
                   instr, rvc, pc, ierr, e.instr, e.rvc, e.pc, e.ierr);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] i, input logic r, input logic [31:0] p, input logic e);
    sb.push_back('{instr: i, rvc: r, pc: p, ierr: e});
  endtask

  task automatic apply_reset();
    rst = 1'b1; flush = 1'b0; flush_addr = '0; fvalid = 1'b0;
    fdata = '0; ferr = 1'b0; iready = 1'b0;
    sb.delete();
    tick(); tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic wait_drain(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (sb.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0; flush_addr = '0; fvalid = 1'b0;
    fdata = '0; ferr = 1'b0; iready = 1'b0;
    #1;
    checks++; if (ivalid !== 1'b0) begin errors++; $display("FAIL reset_ivalid: got %b, expected 0", ivalid); end
    checks++; if (fready !== 1'b1) begin errors++; $display("FAIL reset_fready: got %b, expected 1", fready); end
    checks++; if (rvc !== 1'b0) begin errors++; $display("FAIL reset_rvc: got %b, expected 0", rvc); end
    checks++; if (ierr !== 1'b0) begin errors++; $display("FAIL reset_ierr: got %b, expected 0", ierr); end
    checks++; if (instr !== 32'h0) begin errors++; $display("FAIL reset_instr: got %h, expected 0", instr); end
    checks++; if (pc !== BOOT) begin errors++; $display("FAIL reset_pc: got %h, expected %h", pc, BOOT); end
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_rvc_seq();
    bit ok;
    apply_reset();
    push(32'h0000_4501, 1'b1, 32'h0, 1'b0);
    push(32'h0000_4505, 1'b1, 32'h2, 1'b0);
    push(32'h0000_8082, 1'b1, 32'h4, 1'b0);
    fvalid = 1'b1; fdata = 32'h4505_4501;
    tick();
    fdata = 32'h0000_8082;
    tick();
    fvalid = 1'b0;
    iready = 1'b1;
    wait_drain(ok);
    iready = 1'b0;
    checks++; if (!ok) begin errors++; $display("FAIL rvc_seq_drain: %0d outputs missing, expected 0", sb.size()); end
    checks++; if (ivalid !== 1'b1) begin errors++; $display("FAIL rvc_seq_tail_valid: got %b, expected 1", ivalid); end
    checks++; if ({instr, rvc, pc} !== {32'h0, 1'b1, 32'h6}) begin
      errors++; $display("FAIL rvc_seq_tail: got instr=%h rvc=%b pc=%h, expected instr=0 rvc=1 pc=6", instr, rvc, pc);
    end
  endtask

  task automatic test_spanning();
    bit ok;
    apply_reset();
    push(32'h0000_4501, 1'b1, 32'h0, 1'b0);
    push(32'h0010_0093, 1'b0, 32'h2, 1'b0);
    iready = 1'b1;
    fvalid = 1'b1; fdata = 32'h0093_4501;
    tick();
    fvalid = 1'b0;
    tick();
    for (int i = 0; i < 3; i++) begin
      checks++; if (ivalid !== 1'b0) begin errors++; $display("FAIL span_wait_%0d: ivalid=%b, expected 0", i, ivalid); end
      tick();
    end
    fvalid = 1'b1; fdata = 32'h0000_0010;
    tick();
    fvalid = 1'b0;
    checks++; if (ivalid !== 1'b1 || rvc !== 1'b0) begin
      errors++; $display("FAIL span_ready: ivalid=%b rvc=%b, expected ivalid=1 rvc=0", ivalid, rvc);
    end
    wait_drain(ok);
    iready = 1'b0;
    checks++; if (!ok) begin errors++; $display("FAIL span_drain: %0d outputs missing, expected 0", sb.size()); end
  endtask

  task automatic test_flush();
    bit ok;
    apply_reset();
    fvalid = 1'b1; fdata = 32'h4505_4501;
    tick();
    fvalid = 1'b1; fdata = 32'hDEAD_BEEF;
    flush = 1'b1; flush_addr = 32'h0000_0102; iready = 1'b1;
    #1;
    checks++; if (ivalid !== 1'b0) begin errors++; $display("FAIL flush_cycle_ivalid: got %b, expected 0", ivalid); end
    tick();
    flush = 1'b0; fvalid = 1'b0;
    checks++; if (ivalid !== 1'b0) begin errors++; $display("FAIL flush_dropped_word: ivalid=%b, expected 0", ivalid); end
    checks++; if (pc !== 32'h0000_0102) begin errors++; $display("FAIL flush_pc: got %h, expected 00000102", pc); end
    push(32'h0000_4505, 1'b1, 32'h0000_0102, 1'b0);
    fvalid = 1'b1; fdata = 32'h4505_1111;
    tick();
    fvalid = 1'b0;
    wait_drain(ok);
    iready = 1'b0;
    checks++; if (!ok) begin errors++; $display("FAIL flush_drain: %0d outputs missing, expected 0", sb.size()); end
    checks++; if (pc !== 32'h0000_0104 || ivalid !== 1'b0) begin
      errors++; $display("FAIL flush_after: pc=%h ivalid=%b, expected pc=00000104 ivalid=0", pc, ivalid);
    end
  endtask

  task automatic test_backpressure();
    bit ok;
    apply_reset();
    fvalid = 1'b1; fdata = 32'h4505_4501;
    #1;
    checks++; if (fready !== 1'b1) begin errors++; $display("FAIL bp_word0: fready=%b, expected 1", fready); end
    tick();
    checks++; if (fready !== 1'b1) begin errors++; $display("FAIL bp_word1: fready=%b, expected 1", fready); end
    tick();
    checks++; if (fready !== 1'b0) begin errors++; $display("FAIL bp_full: fready=%b, expected 0", fready); end
    tick();
    checks++; if (fready !== 1'b0) begin errors++; $display("FAIL bp_full_hold: fready=%b, expected 0", fready); end
    push(32'h0000_4501, 1'b1, 32'h0, 1'b0);
    iready = 1'b1;
    tick();
    iready = 1'b0;
    checks++; if (fready !== 1'b0) begin errors++; $display("FAIL bp_count3: fready=%b, expected 0", fready); end
    push(32'h0000_4505, 1'b1, 32'h2, 1'b0);
    iready = 1'b1;
    tick();
    iready = 1'b0; fvalid = 1'b0;
    checks++; if (fready !== 1'b1) begin errors++; $display("FAIL bp_count2: fready=%b, expected 1", fready); end
    push(32'h0000_4501, 1'b1, 32'h4, 1'b0);
    push(32'h0000_4505, 1'b1, 32'h6, 1'b0);
    iready = 1'b1;
    wait_drain(ok);
    iready = 1'b0;
    checks++; if (!ok) begin errors++; $display("FAIL bp_drain: %0d outputs missing, expected 0", sb.size()); end
    checks++; if (ivalid !== 1'b0) begin errors++; $display("FAIL bp_empty: ivalid=%b, expected 0", ivalid); end
  endtask

  task automatic test_error();
    bit ok;
    apply_reset();
    push(32'h0000_FFFF, 1'b0, 32'h0, 1'b1);
    push(32'h0000_FFFF, 1'b0, 32'h2, 1'b1);
    fvalid = 1'b1; ferr = 1'b1; fdata = 32'hFFFF_FFFF;
    tick();
    fvalid = 1'b0; ferr = 1'b0;
    checks++; if (ivalid !== 1'b1 || ierr !== 1'b1) begin
      errors++; $display("FAIL err_next_cycle: ivalid=%b ierr=%b, expected 1 1", ivalid, ierr);
    end
    iready = 1'b1;
    wait_drain(ok);
    iready = 1'b0;
    checks++; if (!ok) begin errors++; $display("FAIL err_drain: %0d outputs missing, expected 0", sb.size()); end
    checks++; if (pc !== 32'h4 || ivalid !== 1'b0) begin
      errors++; $display("FAIL err_after: pc=%h ivalid=%b, expected pc=00000004 ivalid=0", pc, ivalid);
    end
  endtask

  task automatic test_async_reset();
    apply_reset();
    flush = 1'b1; flush_addr = 32'h0000_0002;
    tick();
    flush = 1'b0;
    fvalid = 1'b1; fdata = 32'h4505_1111;
    tick();
    fdata = 32'h4509_4507;
    tick();
    fvalid = 1'b0;
    checks++; if (ivalid !== 1'b1 || pc !== 32'h2 || instr !== 32'h0000_4505) begin
      errors++; $display("FAIL arst_pre: ivalid=%b pc=%h instr=%h, expected 1 00000002 00004505", ivalid, pc, instr);
    end
    #2;
    rst = 1'b1;
    #1;
    checks++; if (ivalid !== 1'b0) begin errors++; $display("FAIL arst_ivalid: got %b, expected 0", ivalid); end
    checks++; if (fready !== 1'b1) begin errors++; $display("FAIL arst_fready: got %b, expected 1", fready); end
    checks++; if (pc !== BOOT) begin errors++; $display("FAIL arst_pc: got %h, expected %h", pc, BOOT); end
    tick();
    rst = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_rvc_seq();
    test_spanning();
    test_flush();
    test_backpressure();
    test_error();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
